// File: rtl/axis_dac_pkg.sv
// Shared types and helpers for the AXI-Stream DAC player: state encoding,
// midscale constant and lane extraction from a packed stream beat.
package axis_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2,
        ST_TEST    = 2'd3
    } dac_state_e;

    localparam int MAX_DATA_W = 1024;
    localparam int MAX_LANE_W = 64;

    function automatic logic [MAX_LANE_W-1:0] midscale(input int dac_w);
        return (MAX_LANE_W'(1) << (dac_w - 1)) - MAX_LANE_W'(1);
    endfunction

    // Lane 0 sits in the LSBs; callers truncate to the DAC width.
    function automatic logic [MAX_LANE_W-1:0] lane_extract(input logic [MAX_DATA_W-1:0] data,
                                                           input int idx, input int lane_w);
        logic [MAX_DATA_W-1:0] sh;
        sh = data >> (idx * lane_w);
        return sh[MAX_LANE_W-1:0];
    endfunction

endpackage

// File: rtl/axis_dac_beat_fifo.sv
// Synchronous first-word-fall-through beat FIFO with flush. MSB of each entry
// is the TLAST flag; has_last_o reports whether any stored beat carries it.
module axis_dac_beat_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    has_last_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, last_cnt_q;
    logic             push_ok, pop_ok, push_last, pop_last;

    assign full_o     = (level_q == FULL_LVL);
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign has_last_o = (last_cnt_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign push_last  = push_ok && push_data_i[WIDTH-1];
    assign pop_last   = pop_ok && rd_data_o[WIDTH-1];

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_cnt_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_cnt_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q    <= level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
            last_cnt_q <= last_cnt_q + {{AW{1'b0}}, push_last} - {{AW{1'b0}}, pop_last};
        end
    end

endmodule

// File: rtl/axis_dac_stream_player.sv
// AXI4-Stream slave that buffers packed sample beats and plays them lane by
// lane to a DAC at a divided sample rate, with prefill, underrun and ramp test.
module axis_dac_stream_player
    import axis_dac_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int LANE_WIDTH           = 16,
    parameter int DAC_WIDTH            = 14,
    parameter int FIFO_DEPTH           = 16,
    parameter int PREFILL_BEATS        = 4,
    parameter int DIV_WIDTH            = 8
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    input  logic                                streamEnable,
    input  logic                                testMode,
    input  logic [DIV_WIDTH-1:0]                rateDiv,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic [DAC_WIDTH-1:0]                DAC_data,
    output logic                                sample_strobe,
    output logic                                ClockToDAC,
    output logic [1:0]                          state,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic [15:0]                         underrun_count
);
    localparam int SPB   = C_S_AXIS_TDATA_WIDTH / LANE_WIDTH;
    localparam int LW    = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = C_S_AXIS_TDATA_WIDTH + 1;
    localparam logic [DAC_WIDTH-1:0] MID         = DAC_WIDTH'(midscale(DAC_WIDTH));
    localparam logic [LVL_W-1:0]     PREFILL_LVL = PREFILL_BEATS[LVL_W-1:0];
    localparam logic [LW-1:0]        LAST_LANE   = LW'(SPB - 1);

    dac_state_e               state_q;
    logic [DAC_WIDTH-1:0]     dac_q, ramp_q, lane_sample;
    logic                     strobe_q;
    logic [DIV_WIDTH-1:0]     div_q, rate_q;
    logic [LW-1:0]            lane_q;
    logic [15:0]              underrun_q;

    logic [FW-1:0]            fifo_rd;
    logic                     fifo_full, fifo_empty, fifo_has_last;
    logic                     push, pop, flush, tick, last_lane;
    logic                     unused_tstrb;

    assign unused_tstrb  = ^S_AXIS_TSTRB;
    assign S_AXIS_TREADY = S_AXIS_ARESETN && streamEnable && !fifo_full;
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign flush         = !streamEnable && (state_q != ST_TEST);
    assign tick          = (div_q == rate_q);
    assign last_lane     = (lane_q == LAST_LANE);
    assign pop           = (state_q == ST_PLAY) && streamEnable && tick && !fifo_empty && last_lane;
    assign lane_sample   = DAC_WIDTH'(lane_extract(MAX_DATA_W'(fifo_rd[FW-2:0]), 32'(lane_q), LANE_WIDTH));

    axis_dac_beat_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (S_AXIS_ACLK),
        .rst_ni      (S_AXIS_ARESETN),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .pop_i       (pop),
        .rd_data_o   (fifo_rd),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .has_last_o  (fifo_has_last)
    );

    // Behavioural stand-in for an ODDR with D1=0, D2=1: the DAC sees an inverted clock.
    assign ClockToDAC = ~S_AXIS_ACLK;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q    <= ST_IDLE;
            dac_q      <= MID;
            strobe_q   <= 1'b0;
            div_q      <= '0;
            rate_q     <= '0;
            lane_q     <= '0;
            ramp_q     <= MID;
            underrun_q <= '0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    div_q  <= '0;
                    rate_q <= rateDiv;
                    lane_q <= '0;
                    ramp_q <= MID;
                    dac_q  <= MID;
                    if (testMode)          state_q <= ST_TEST;
                    else if (streamEnable) state_q <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    div_q  <= '0;
                    rate_q <= rateDiv;
                    if (!streamEnable) begin
                        state_q <= ST_IDLE;
                        lane_q  <= '0;
                        dac_q   <= MID;
                    end else if (fifo_level >= PREFILL_LVL || fifo_has_last) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!streamEnable) begin
                        state_q <= ST_IDLE;
                        lane_q  <= '0;
                        dac_q   <= MID;
                    end else if (tick) begin
                        div_q  <= '0;
                        rate_q <= rateDiv;
                        if (fifo_empty) begin
                            if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
                            dac_q   <= MID;
                            state_q <= ST_PREFILL;
                        end else begin
                            dac_q    <= lane_sample;
                            strobe_q <= 1'b1;
                            if (last_lane) begin
                                lane_q <= '0;
                                if (fifo_rd[FW-1]) state_q <= ST_IDLE;
                            end else begin
                                lane_q <= lane_q + LW'(1);
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_WIDTH'(1);
                    end
                end
                ST_TEST: begin
                    if (!testMode) begin
                        state_q <= ST_IDLE;
                        dac_q   <= MID;
                    end else if (tick) begin
                        div_q    <= '0;
                        rate_q   <= rateDiv;
                        dac_q    <= ramp_q;
                        ramp_q   <= ramp_q + DAC_WIDTH'(1);
                        strobe_q <= 1'b1;
                    end else begin
                        div_q <= div_q + DIV_WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DAC_data       = dac_q;
    assign sample_strobe  = strobe_q;
    assign state          = state_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_axis_dac_stream_player.sv
// Directed bench for axis_dac_stream_player: frame playback, rate divider,
// underrun recovery, FIFO full/flush, async reset and ramp test mode.
module tb_axis_dac_stream_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        streamEnable = 1'b0;
    logic        testMode = 1'b0;
    logic [7:0]  rateDiv = 8'd0;
    logic        tready;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = 4'hF;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic [13:0] dac;
    logic        strobe;
    logic        clk_dac;
    logic [1:0]  st;
    logic [4:0]  level;
    logic [15:0] urun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [13:0] sq[$];
    int          sc[$];

    axis_dac_stream_player dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .streamEnable   (streamEnable),
        .testMode       (testMode),
        .rateDiv        (rateDiv),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .S_AXIS_TVALID  (tvalid),
        .DAC_data       (dac),
        .sample_strobe  (strobe),
        .ClockToDAC     (clk_dac),
        .state          (st),
        .fifo_level     (level),
        .underrun_count (urun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (strobe) begin
            sq.push_back(dac);
            sc.push_back(cyc);
        end
    end

    task automatic push(input logic [31:0] d, input logic l, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            tvalid = 1'b1; tdata = d; tlast = l;
            #1;
            if (tready) ok = 1'b1;
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic wait_samples(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk); #1;
            if (sq.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic stop_stream();
        @(negedge clk);
        streamEnable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL rst_dac got=%h exp=1fff", dac); end
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", tready); end
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", st); end
        checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL rst_strobe got=%b exp=0", strobe); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL idle_dac got=%h exp=1fff", dac); end
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", st); end
        checks++; if (urun !== 16'd0) begin failures++; $display("FAIL idle_urun got=%0d exp=0", urun); end
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL idle_tready got=%b exp=0", tready); end
    endtask

    task automatic test_frame();
        bit ok;
        int acc = 0;
        sq.delete(); sc.delete();
        @(negedge clk); rateDiv = 8'd0; streamEnable = 1'b1;
        for (int b = 0; b < 4; b++) begin
            push({16'(2*b+2), 16'(2*b+1)}, (b == 3), 20, ok);
            if (ok) acc++;
        end
        checks++; if (acc != 4) begin failures++; $display("FAIL frame_push got=%0d exp=4", acc); end
        wait_samples(8, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL frame_timeout got=%0d exp=8", sq.size()); end
        if (ok) begin
            checks++; if (st !== 2'd0) begin failures++; $display("FAIL frame_end_state got=%0d exp=0", st); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (sq[i] !== 14'(i + 1)) begin failures++; $display("FAIL frame_val[%0d] got=%h exp=%h", i, sq[i], 14'(i + 1)); end
                if (i > 0) begin
                    checks++;
                    if (sc[i] - sc[i-1] != 1) begin failures++; $display("FAIL frame_gap[%0d] got=%0d exp=1", i, sc[i] - sc[i-1]); end
                end
            end
            @(negedge clk); #1;
            checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL frame_mid got=%h exp=1fff", dac); end
        end
        stop_stream();
    endtask

    task automatic test_rate();
        bit ok;
        sq.delete(); sc.delete();
        @(negedge clk); rateDiv = 8'd3; streamEnable = 1'b1;
        for (int b = 0; b < 4; b++) push({16'(16'h0102 + 2*b), 16'(16'h0101 + 2*b)}, (b == 3), 20, ok);
        wait_samples(8, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rate_timeout got=%0d exp=8", sq.size()); end
        if (ok) begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (sc[i] - sc[i-1] != 4) begin failures++; $display("FAIL rate_gap[%0d] got=%0d exp=4", i, sc[i] - sc[i-1]); end
            end
            checks++; if (sq[0] !== 14'h0101) begin failures++; $display("FAIL rate_first got=%h exp=0101", sq[0]); end
            checks++; if (sq[7] !== 14'h0108) begin failures++; $display("FAIL rate_last got=%h exp=0108", sq[7]); end
        end
        stop_stream();
    endtask

    task automatic test_underrun();
        bit ok;
        sq.delete(); sc.delete();
        @(negedge clk); rateDiv = 8'd0; streamEnable = 1'b1;
        for (int b = 0; b < 4; b++) push({16'(16'h0022 + 2*b), 16'(16'h0021 + 2*b)}, 1'b0, 20, ok);
        wait_samples(8, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL urun_timeout got=%0d exp=8", sq.size()); end
        checks++; if (ok && sq[7] !== 14'h0028) begin failures++; $display("FAIL urun_last got=%h exp=0028", sq[7]); end
        @(negedge clk); #1;
        checks++; if (urun !== 16'd1) begin failures++; $display("FAIL urun_count got=%0d exp=1", urun); end
        checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL urun_dac got=%h exp=1fff", dac); end
        checks++; if (st !== 2'd1) begin failures++; $display("FAIL urun_state got=%0d exp=1", st); end
        for (int b = 0; b < 4; b++) push({16'(16'h0032 + 2*b), 16'(16'h0031 + 2*b)}, (b == 3), 20, ok);
        wait_samples(16, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL resume_timeout got=%0d exp=16", sq.size()); end
        if (ok) begin
            checks++; if (sq[8] !== 14'h0031) begin failures++; $display("FAIL resume_first got=%h exp=0031", sq[8]); end
            checks++; if (sq[15] !== 14'h0038) begin failures++; $display("FAIL resume_last got=%h exp=0038", sq[15]); end
            checks++; if (st !== 2'd0) begin failures++; $display("FAIL resume_state got=%0d exp=0", st); end
        end
        stop_stream();
    endtask

    task automatic test_full();
        bit ok;
        int acc = 0;
        @(negedge clk); rateDiv = 8'd255; streamEnable = 1'b1;
        for (int b = 0; b < 16; b++) begin
            push(32'(b), 1'b0, 5, ok);
            if (ok) acc++;
        end
        #1;
        checks++; if (acc != 16) begin failures++; $display("FAIL full_acc got=%0d exp=16", acc); end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", level); end
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL full_tready got=%b exp=0", tready); end
        push(32'hDEAD, 1'b0, 4, ok);
        checks++; if (ok) begin failures++; $display("FAIL full_17th got=%b exp=0", ok); end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_level2 got=%0d exp=16", level); end
        @(negedge clk); streamEnable = 1'b0;
        @(negedge clk); #1;
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL flush_state got=%0d exp=0", st); end
        checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL flush_dac got=%h exp=1fff", dac); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_midreset();
        bit ok;
        sq.delete(); sc.delete();
        @(negedge clk); rateDiv = 8'd3; streamEnable = 1'b1;
        for (int b = 0; b < 4; b++) push({16'(16'h0042 + 2*b), 16'(16'h0041 + 2*b)}, (b == 3), 20, ok);
        wait_samples(2, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mrst_timeout got=%0d exp=2", sq.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL mrst_dac got=%h exp=1fff", dac); end
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL mrst_state got=%0d exp=0", st); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL mrst_level got=%0d exp=0", level); end
        checks++; if (urun !== 16'd0) begin failures++; $display("FAIL mrst_urun got=%0d exp=0", urun); end
        @(negedge clk); streamEnable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ramp();
        bit ok;
        sq.delete(); sc.delete();
        @(negedge clk); rateDiv = 8'd0; testMode = 1'b1;
        wait_samples(8194, 9000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ramp_timeout got=%0d exp=8194", sq.size()); end
        checks++; if (st !== 2'd3) begin failures++; $display("FAIL ramp_state got=%0d exp=3", st); end
        if (ok) begin
            checks++; if (sq[0] !== 14'h1FFF) begin failures++; $display("FAIL ramp_0 got=%h exp=1fff", sq[0]); end
            checks++; if (sq[1] !== 14'h2000) begin failures++; $display("FAIL ramp_1 got=%h exp=2000", sq[1]); end
            checks++; if (sq[8192] !== 14'h3FFF) begin failures++; $display("FAIL ramp_top got=%h exp=3fff", sq[8192]); end
            checks++; if (sq[8193] !== 14'h0000) begin failures++; $display("FAIL ramp_wrap got=%h exp=0000", sq[8193]); end
        end
        @(negedge clk); testMode = 1'b0;
        @(negedge clk); #1;
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL ramp_exit_state got=%0d exp=0", st); end
        checks++; if (dac !== 14'h1FFF) begin failures++; $display("FAIL ramp_exit_dac got=%h exp=1fff", dac); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_rate();
        test_underrun();
        test_full();
        test_midreset();
        test_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_dac_stream_player.md
# axis_dac_stream_player

- Parametrised AXI4-Stream slave that replaces the fixed two-sample AXIS-to-AD9764 path.
- Buffers incoming beats in a FIFO and unpacks N samples per beat.
- Plays samples to a DAC of configurable width at a programmable sample rate (clock divider).
- Adds prefill, frame end on TLAST, underrun detection/counting, and a ramp test mode. Sits between the DMA stream and the DAC pins in the transmit chain.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32: stream width; multiple of LANE_WIDTH.
- LANE_WIDTH, 16: bits per sample lane; SAMPLES_PER_BEAT = C_S_AXIS_TDATA_WIDTH/LANE_WIDTH.
- DAC_WIDTH, 14: DAC bits; ≤ LANE_WIDTH; sample = lane[DAC_WIDTH-1:0].
- FIFO_DEPTH, 16: beats; power of 2, ≥ 2.
- PREFILL_BEATS, 4: beats required before playback starts; 1..FIFO_DEPTH.
- DIV_WIDTH, 8: width of rateDiv.

Ports:
- S_AXIS_ACLK  in  1  sole clock.
- S_AXIS_ARESETN  in  1  reset. **Asynchronous, active-low.**
- streamEnable  in  1  permits playback; low aborts and flushes.
- testMode  in  1  requests ramp test output.
- rateDiv  in  DIV_WIDTH  one sample tick every rateDiv+1 cycles.
- S_AXIS_TREADY  out  1  high when streamEnable and FIFO not full.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  packed samples; lane 0 = LSBs.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored.
- S_AXIS_TLAST  in  1  marks the final beat of a frame.
- S_AXIS_TVALID  in  1  beat valid.
- DAC_data  out  DAC_WIDTH  registered DAC word.
- sample_strobe  out  1  one-cycle pulse, aligned with each new DAC_data value.
- ClockToDAC  out  1  forwarded clock through the ODDR primitive (D1=0, D2=1).
- state  out  2  current state encoding.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  beats stored.
- underrun_count  out  16  saturating underrun count.

## Operation
- MIDSCALE = 2^(DAC_WIDTH-1)-1 (0x1FFF for 14 bits).
- States and encodings:
  - IDLE = 0
  - PREFILL = 1
  - PLAY = 2
  - TEST = 3
- IDLE:
  - testMode high → TEST.
  - Otherwise, streamEnable high → PREFILL.
  - DAC_data = MIDSCALE.
- PREFILL:
  - Go to PLAY when fifo_level ≥ PREFILL_BEATS, or when the FIFO holds a beat with TLAST.
  - streamEnable low → IDLE.
- PLAY:
  - On each tick, output the current lane, then advance the lane index (0..SAMPLES_PER_BEAT-1).
  - After the last lane, pop the beat.
  - If that beat carried TLAST → IDLE after its last lane is output.
  - If a tick needs a new beat and the FIFO is empty: underrun. underrun_count increments, saturating at 0xFFFF. DAC_data = MIDSCALE. State → PREFILL.
- TEST:
  - Ramp starts at MIDSCALE and adds 1 per tick, wrapping modulo 2^DAC_WIDTH.
  - testMode low → IDLE next cycle.
  - testMode is ignored outside IDLE/TEST.
- streamEnable low in any non-TEST state:
  - State → IDLE next cycle.
  - FIFO flushed, lane index cleared.
  - TREADY low.
  - DAC_data = MIDSCALE.
- Push when TVALID && TREADY, storing {TLAST, TDATA}. Simultaneous push and pop is allowed; level is unchanged.

## Timing
- Reset values:
  - DAC_data = MIDSCALE; state = IDLE.
  - TREADY = 0; sample_strobe = 0.
  - fifo_level = 0; underrun_count = 0.
  - Divider = 0; lane index = 0; ramp = MIDSCALE.
- Divider:
  - Counts 0..rateDiv only in PLAY/TEST; tick when count == rateDiv.
  - Cleared on entering PLAY/TEST, so the first tick occurs rateDiv+1 cycles after entry.
  - rateDiv = 0 gives a tick every cycle.
  - A rateDiv change takes effect at the next wrap.
- Latency: DAC_data and sample_strobe update 1 cycle after the tick.
- Push to fifo_level visible: 1 cycle. TREADY deasserts in the same cycle fifo_level reaches FIFO_DEPTH (combinational from the full flag).
- Full FIFO: no push even if a pop occurs that cycle.
- Reset asserted mid-frame: everything returns to reset values immediately (async). ClockToDAC keeps running.

## Structure
- Package axis_dac_pkg contains:
  - the state enum and its encodings;
  - a midscale(DAC_WIDTH) function;
  - the lane-extraction function.
- Sub-module axis_dac_beat_fifo: synchronous FIFO of width C_S_AXIS_TDATA_WIDTH+1 (TLAST bit), depth FIFO_DEPTH.
  - Provides level, full, empty, flush.
  - First-word-fall-through read.

## Test plan
- Reset release, streamEnable=0 → DAC_data=0x1FFF, TREADY=0, state=0, underrun_count=0.
- PREFILL_BEATS=4, rateDiv=0: push 4 beats 0x0002_0001 … 0x0008_0007, last with TLAST → DAC sequence 1,2,…,8, one per cycle, then 0x1FFF; state returns to IDLE.
- rateDiv=3 → sample_strobe every 4 cycles; each DAC_data value held 4 cycles.
- Feed 4 beats without TLAST, then stop TVALID → after the 8th sample, underrun_count=1, DAC_data=0x1FFF, state=PREFILL. Resupply 4 beats → playback resumes.
- Fill the FIFO to 16 with playback blocked (PREFILL_BEATS=16, rateDiv=255) → TREADY low at level 16, no 17th beat accepted. Deassert streamEnable → fifo_level=0, state=IDLE.
- testMode=1, rateDiv=0 → DAC_data 0x1FFF, 0x2000, …, reaching 0x3FFF then wrapping to 0x0000. testMode=0 → IDLE, DAC_data=0x1FFF.
